// File: rtl/piso_shift_reg.sv
// Parallel-in/serial-out shift register: loads an N-bit word and serialises it LSB-first.
// Optional build macro PISO_PARITY_EN appends an even-parity bit to every frame.

module mux2 (
  input  logic d0,
  input  logic d1,
  input  logic sel,
  output logic y
);
  assign y = sel ? d1 : d0;
endmodule

module piso_shift_reg #(
  parameter int N          = 8,
  parameter int CLK_PERIOD = 100
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic [N-1:0]           din,
  output logic                   ready,
  output logic                   sout,
  output logic                   sout_valid,
  output logic                   done,
  output logic [$clog2(N+1)-1:0] bit_cnt
);
  localparam int CW = $clog2(N+1);
`ifdef PISO_PARITY_EN
  localparam int FRAME = N + 1;
`else
  localparam int FRAME = N;
`endif
  localparam logic [CW-1:0] LAST = CW'(FRAME - 1);

  generate
    if (N < 2 || N > 32) begin : g_bad_n
      $error("piso_shift_reg: N out of range");
    end
    if (CLK_PERIOD < 40) begin : g_bad_clk
      $error("piso_shift_reg: CLK_PERIOD below mux2 path delay");
    end
  endgenerate

  typedef enum logic {IDLE, SHIFT} state_e;

  state_e          state_q, state_d;
  logic [N-1:0]    sreg_q, sreg_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            done_q, done_d;
  logic            load_acc;
  logic [N-1:0]    shift_src;
  logic [N-1:0]    mux_y;

  assign ready     = (state_q == IDLE);
  assign load_acc  = load & ready;
  assign shift_src = {1'b0, sreg_q[N-1:1]};

  // One mux2 cell per bit picks between the shift path and the parallel word.
  for (genvar gi = 0; gi < N; gi++) begin : g_bit
    mux2 u_mux (
      .d0  (shift_src[gi]),
      .d1  (din[gi]),
      .sel (load_acc),
      .y   (mux_y[gi])
    );
  end

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_acc) begin
          sreg_d  = mux_y;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        sreg_d = mux_y;
        if (cnt_q == LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

`ifdef PISO_PARITY_EN
  logic par_q, par_d;

  assign par_d = load_acc ? ^din : par_q;

  always_ff @(posedge clk) begin
    if (rst) par_q <= 1'b0;
    else     par_q <= par_d;
  end

  // Data bits are exhausted once the count reaches N; the parity flop drives the tail bit.
  assign sout = (state_q == SHIFT && cnt_q == CW'(N)) ? par_q : sreg_q[0];
`else
  assign sout = sreg_q[0];
`endif

  assign sout_valid = (state_q == SHIFT);
  assign done       = done_q;
  assign bit_cnt    = cnt_q;
endmodule

// File: tb/tb_piso_shift_reg.sv
// Directed bench for piso_shift_reg: serial bits are checked against a queue of
// expected bits filled when each word is loaded.

module tb_piso_shift_reg;
  localparam int N  = 8;
  localparam int CW = $clog2(N+1);
`ifdef PISO_PARITY_EN
  localparam int FL = N + 1;
`else
  localparam int FL = N;
`endif

  logic          clk = 1'b0;
  logic          rst, load;
  logic [N-1:0]  din;
  logic          ready, sout, sout_valid, done;
  logic [CW-1:0] bit_cnt;

  int   total = 0;
  int   bad   = 0;
  int   done_cnt = 0;
  logic exp_q[$];

  piso_shift_reg #(.N(N), .CLK_PERIOD(100)) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .din        (din),
    .ready      (ready),
    .sout       (sout),
    .sout_valid (sout_valid),
    .done       (done),
    .bit_cnt    (bit_cnt)
  );

  always #50 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [N-1:0] w);
    for (int i = 0; i < N; i++) exp_q.push_back(w[i]);
`ifdef PISO_PARITY_EN
    exp_q.push_back(^w);
`endif
  endtask

  // Advance one edge, then score any serial bit the DUT presents.
  task automatic tick();
    logic e;
    @(posedge clk);
    #1;
    if (sout_valid === 1'b1) begin
      if (exp_q.size() == 0) chk("extra_bit", 32'd1, 32'd0);
      else begin
        e = exp_q.pop_front();
        chk("sout", {31'd0, sout}, {31'd0, e});
      end
    end
    if (done === 1'b1) done_cnt++;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_ready"}, {31'd0, ready}, 32'd1);
    chk({tag, "_valid"}, {31'd0, sout_valid}, 32'd0);
    chk({tag, "_cnt"},   {{(32-CW){1'b0}}, bit_cnt}, 32'd0);
  endtask

  // Load one word, run it out, and check the done pulse and return to idle.
  task automatic run_frame(input string tag, input logic [N-1:0] w);
    int d0;
    d0 = done_cnt;
    push_word(w);
    load = 1'b1; din = w;
    tick();
    load = 1'b0; din = 'x;
    chk({tag, "_busy"}, {31'd0, ready}, 32'd0);
    for (int k = 1; k < FL; k++) begin
      tick();
      chk({tag, "_bitcnt"}, {{(32-CW){1'b0}}, bit_cnt}, k);
    end
    tick();
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    check_idle(tag);
    tick();
    chk({tag, "_done_clr"}, {31'd0, done}, 32'd0);
    chk({tag, "_done_cnt"}, done_cnt - d0, 32'd1);
    chk({tag, "_q_empty"}, exp_q.size(), 32'd0);
  endtask

  initial begin
    int d0;
    rst = 1'b1; load = 1'b0; din = '0;
    tick();
    tick();
    rst = 1'b0;
    check_idle("reset");
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_sout", {31'd0, sout}, 32'd0);

    run_frame("basic_a5", 8'hA5);
    run_frame("par_07", 8'h07);
    run_frame("par_03", 8'h03);

    // load while busy: 8'h3C must never reach the line
    d0 = done_cnt;
    push_word(8'hFF);
    load = 1'b1; din = 8'hFF;
    tick();
    load = 1'b0;
    tick();
    tick();
    load = 1'b1; din = 8'h3C;
    tick();
    load = 1'b0;
    for (int k = 4; k < FL; k++) tick();
    tick();
    chk("busy_done", {31'd0, done}, 32'd1);
    tick();
    chk("busy_done_cnt", done_cnt - d0, 32'd1);
    chk("busy_q_empty", exp_q.size(), 32'd0);

    // back-to-back: second word accepted on the done cycle
    d0 = done_cnt;
    push_word(8'h01);
    push_word(8'h80);
    load = 1'b1; din = 8'h01;
    tick();
    din = 8'h80;
    for (int k = 1; k < FL; k++) tick();
    tick();
    chk("b2b_gap_done", {31'd0, done}, 32'd1);
    chk("b2b_gap_valid", {31'd0, sout_valid}, 32'd0);
    tick();
    load = 1'b0;
    chk("b2b_second_valid", {31'd0, sout_valid}, 32'd1);
    for (int k = 1; k < FL; k++) tick();
    tick();
    chk("b2b_done2", {31'd0, done}, 32'd1);
    tick();
    chk("b2b_done_cnt", done_cnt - d0, 32'd2);
    chk("b2b_q_empty", exp_q.size(), 32'd0);

    // reset mid-frame after bits 0..3 of 8'hF0
    d0 = done_cnt;
    for (int i = 0; i < 4; i++) exp_q.push_back(1'b0);
    load = 1'b1; din = 8'hF0;
    tick();
    load = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle("midrst");
    chk("midrst_done", {31'd0, done}, 32'd0);
    tick();
    tick();
    chk("midrst_no_done", done_cnt - d0, 32'd0);
    chk("midrst_q_empty", exp_q.size(), 32'd0);

    // rst and load together: rst wins
    rst = 1'b1; load = 1'b1; din = 8'h55;
    tick();
    rst = 1'b0; load = 1'b0;
    check_idle("rst_load");
    tick();
    chk("rst_load_valid", {31'd0, sout_valid}, 32'd0);

    for (int r = 0; r < 4; r++) run_frame("rand", N'($urandom));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
